// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 event queue: parser states, prefix bytes,
// dropped keyboard responses and the packed key-event record.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_REL     = 3'd2,
    ST_EXT_REL = 3'd3,
    ST_PAUSE   = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam int unsigned PAUSE_SKIP    = 7;

  localparam int unsigned EV_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard responses (BAT, ACK, echo, resend, errors) that are not keys.
  function automatic logic is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    case (b)
      8'h00, 8'hFF, 8'hAA, 8'hFA,
      8'hEE, 8'hFC, 8'hFD, 8'hFE: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head,
// so the outputs keep the last delivered entry while the FIFO is empty.
module ps2_event_fifo #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  drop
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_next;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  push_ok;
  logic                  pop_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;
    rd_next = rd_ptr_q + 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_next;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The head register tracks whatever entry will sit at rd_ptr next cycle.
    if (push_ok && (empty || (pop_ok && count_q == (DEPTH_LOG2+1)'(1)))) begin
      head_d = push_data;
    end else if (pop_ok && count_q > (DEPTH_LOG2+1)'(1)) begin
      head_d = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/ps2_event_queue.sv
// Folds the PS/2 receiver byte stream into {ext, release, code} key events,
// queues them for a valid/ready consumer and keeps sticky error status.
module ps2_event_queue
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            code,
  input  logic                  strobe,
  input  logic                  err,
  input  logic                  ev_ready,
  output logic                  ev_valid,
  output logic [7:0]            ev_code,
  output logic                  ev_ext,
  output logic                  ev_release,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  rx_error,
  input  logic                  clr_status
);

  // Handshake: an event is consumed on every cycle where ev_valid && ev_ready;
  // ev_ready with ev_valid low has no effect, ev_valid never waits on ev_ready.

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             overflow_q, overflow_d;
  logic             rx_error_q, rx_error_d;

  logic             ev_push;
  ps2_event_t       ev_data;
  ps2_event_t       head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    tmo_inc = tmo_q + 1'b1;
    ev_push = 1'b0;
    ev_data = '0;
    if (err) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      tmo_d   = '0;
    end else if (strobe) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (code == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (code == PS2_REL) begin
            state_d = ST_REL;
          end else if (code == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = 3'(PAUSE_SKIP);
          end else if (!is_dropped(code)) begin
            ev_push = 1'b1;
            ev_data = '{ext: 1'b0, rel: 1'b0, code: code};
          end
        end
        ST_EXT: begin
          if (code == PS2_REL) begin
            state_d = ST_EXT_REL;
          end else begin
            state_d = ST_IDLE;
            ev_push = 1'b1;
            ev_data = '{ext: 1'b1, rel: 1'b0, code: code};
          end
        end
        ST_REL: begin
          state_d = ST_IDLE;
          ev_push = 1'b1;
          ev_data = '{ext: 1'b0, rel: 1'b1, code: code};
        end
        ST_EXT_REL: begin
          state_d = ST_IDLE;
          ev_push = 1'b1;
          ev_data = '{ext: 1'b1, rel: 1'b1, code: code};
        end
        ST_PAUSE: begin
          // The whole 8-byte Pause make collapses into a single event.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            ev_push = 1'b1;
            ev_data = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE_CODE};
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // A lost byte would otherwise leave the parser stuck mid-sequence.
      if (tmo_inc == TMO_LAST) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_inc;
      end
    end
  end

  always_comb begin
    overflow_d = (overflow_q && !clr_status) || fifo_drop;
    rx_error_d = (rx_error_q && !clr_status) || err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
      rx_error_q <= rx_error_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH      (EV_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_push),
    .push_data (ev_data),
    .pop       (ev_ready),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count),
    .drop      (fifo_drop)
  );

  assign ev_valid   = !fifo_empty;
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_release = head.rel;
  assign overflow   = overflow_q;
  assign rx_error   = rx_error_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_event_queue.sv
// Directed bench for ps2_event_queue: a byte-sequence model with an event
// queue is checked every cycle, plus literal expectations at key points.
module tb_ps2_event_queue;

  localparam int unsigned DEPTH_LOG2 = 3;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned TMO        = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          code;
  logic                strobe;
  logic                err;
  logic                ev_ready;
  logic                ev_valid;
  logic [7:0]          ev_code;
  logic                ev_ext;
  logic                ev_release;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                rx_error;
  logic                clr_status;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_event_queue #(
    .DEPTH_LOG2     (DEPTH_LOG2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .strobe     (strobe),
    .err        (err),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .count      (count),
    .overflow   (overflow),
    .rx_error   (rx_error),
    .clr_status (clr_status)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] pend[$];
  logic [9:0] exp_q[$];
  logic [9:0] last_head;
  int         idle_cnt;
  logic       m_ovf;
  logic       m_rxe;
  bit         model_live = 0;
  bit         m_have;
  bit         m_pop;
  logic [9:0] m_ev;

  function automatic void parse(input logic [7:0] b, output bit have, output logic [9:0] ev);
    have = 0;
    ev   = '0;
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
      else if (!(b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hFE})) begin
        have = 1;
        ev   = {2'b00, b};
      end
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        have = 1;
        ev   = {2'b10, 8'h77};
        pend.delete();
      end
    end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
      pend.push_back(b);
    end else begin
      have = 1;
      ev   = {pend[0] == 8'hE0, pend[pend.size()-1] == 8'hF0, b};
      pend.delete();
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      exp_q.delete();
      last_head = '0;
      idle_cnt  = 0;
      m_ovf     = 0;
      m_rxe     = 0;
    end else begin
      m_have = 0;
      m_ev   = '0;
      m_pop  = ev_ready && exp_q.size() != 0;
      if (err) begin
        pend.delete();
        idle_cnt = 0;
      end else if (strobe) begin
        idle_cnt = 0;
        parse(code, m_have, m_ev);
      end else if (pend.size() != 0) begin
        idle_cnt++;
        if (idle_cnt == TMO - 1) begin
          pend.delete();
          idle_cnt = 0;
        end
      end
      if (clr_status) begin
        m_ovf = 0;
        m_rxe = 0;
      end
      if (err) m_rxe = 1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ev);
        else m_ovf = 1;
      end
      if (exp_q.size() != 0) last_head = exp_q[0];
    end
    model_live = 1;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("sb_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
      check("sb_count", 32'(count), 32'(exp_q.size()));
      check("sb_head", {22'd0, ev_ext, ev_release, ev_code}, {22'd0, last_head});
      check("sb_overflow", 32'(overflow), 32'(m_ovf));
      check("sb_rx_error", 32'(rx_error), 32'(m_rxe));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code   = b;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic check_head(input string name, input logic ext, input logic rel, input logic [7:0] c);
    check({name, "_valid"}, 32'(ev_valid), 32'd1);
    check(name, {22'd0, ev_ext, ev_release, ev_code}, {22'd0, ext, rel, c});
  endtask

  logic [7:0] fill_codes  [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] drain_codes [8] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4D};
  logic [7:0] pause_seq   [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; code = '0; strobe = 0; err = 0; ev_ready = 0; clr_status = 0;
    repeat (3) tick();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_head", {22'd0, ev_ext, ev_release, ev_code}, 32'd0);
    check("rst_status", {30'd0, overflow, rx_error}, 32'd0);
    reset = 1'b0;
    tick();

    // make then release with consumer ready
    ev_ready = 1;
    check("pre_valid", 32'(ev_valid), 32'd0);
    send(8'h1C);
    check_head("make_1c", 0, 0, 8'h1C);
    send(8'hF0);
    check("after_pop_count", 32'(count), 32'd0);
    send(8'h1C);
    check_head("break_1c", 0, 1, 8'h1C);
    tick();
    check("drained_count", 32'(count), 32'd0);
    check("hold_release", 32'(ev_release), 32'd1);

    // extended make/break and dropped ACK
    ev_ready = 0;
    send(8'hE0); send(8'h75);
    check_head("ext_make", 1, 0, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hFA);
    check("fa_dropped_count", 32'(count), 32'd2);
    ev_ready = 1;
    tick();
    check_head("ext_break", 1, 1, 8'h75);
    tick();

    // Pause sequence
    ev_ready = 0;
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    check("pause_count", 32'(count), 32'd1);
    check_head("pause_ev", 1, 0, 8'h77);
    send(8'h1C);
    check("pause_then_make", 32'(count), 32'd2);
    ev_ready = 1;
    repeat (2) tick();

    // overflow, simultaneous push/pop when full, drain order
    ev_ready = 0;
    for (int i = 0; i < 9; i++) send(fill_codes[i]);
    check("full_count", 32'(count), 32'd8);
    check("full_overflow", 32'(overflow), 32'd1);
    check_head("full_head", 0, 0, 8'h15);
    ev_ready = 1;
    send(8'h4D);
    check("pushpop_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_head("drain", 0, 0, drain_codes[i]);
      tick();
    end
    check("drain_empty", 32'(ev_valid), 32'd0);
    clr_status = 1; tick(); clr_status = 0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // receive error handling
    send(8'hE0);
    err = 1; tick(); err = 0;
    send(8'h6B);
    check_head("err_resync", 0, 0, 8'h6B);
    check("rx_error_set", 32'(rx_error), 32'd1);
    clr_status = 1; err = 1; tick(); err = 0;
    check("clr_vs_err", 32'(rx_error), 32'd1);
    tick(); clr_status = 0;
    check("rx_error_clr", 32'(rx_error), 32'd0);
    code = 8'h1C; strobe = 1; err = 1; tick(); strobe = 0; err = 0;
    check("err_wins_valid", 32'(ev_valid), 32'd0);
    clr_status = 1; tick(); clr_status = 0;

    // timeout abandons a pending prefix; a short gap does not
    send(8'hE0);
    repeat (TMO) tick();
    send(8'h74);
    check_head("timeout", 0, 0, 8'h74);
    send(8'hE0);
    repeat (3) tick();
    send(8'h74);
    check_head("short_gap", 1, 0, 8'h74);

    // reset in the middle of a sequence
    ev_ready = 0;
    send(8'hF0);
    reset = 1; tick(); reset = 0;
    check("midrst_valid", 32'(ev_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_head", {22'd0, ev_ext, ev_release, ev_code}, 32'd0);
    check("midrst_status", {30'd0, overflow, rx_error}, 32'd0);
    send(8'h1C);
    check_head("after_rst", 0, 0, 8'h1C);
    ev_ready = 1;
    repeat (2) tick();

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
